// File: rtl/puf_resp_collector_if.sv
// Bundles the control, result and PUF-core signals of puf_resp_collector.
// The slave modport is the collector's view; master is the surrounding system.
interface puf_resp_collector_if #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 8
);
  logic                          start;
  logic                          abort;
  logic [WORD_W-1:0]             seed;
  logic [WORD_W-1:0]             puf_challenge;
  logic                          puf_eval;
  logic [WORD_W-1:0]             puf_response;
  logic [WORD_W*NUM_WORDS-1:0]   resp_out;
  logic                          resp_valid;
  logic                          busy;
  logic                          done;
  logic [2:0]                    state;

  modport master (
    output start, abort, seed, puf_response,
    input  puf_challenge, puf_eval, resp_out, resp_valid, busy, done, state
  );

  modport slave (
    input  start, abort, seed, puf_response,
    output puf_challenge, puf_eval, resp_out, resp_valid, busy, done, state
  );
endinterface

// File: rtl/puf_resp_collector.sv
// Expands a seed through a Galois LFSR, evaluates the PUF core once per challenge
// (optionally several times with bitwise majority) and assembles a wide response.
module puf_resp_collector #(
  parameter int                            WORD_W    = 16,
  parameter int                            NUM_WORDS = 8,
  parameter int                            SETTLE    = 2,
  parameter int                            VOTES     = 1,
  parameter logic [WORD_W-1:0]             LFSR_TAPS = 16'hB400,
  parameter logic [WORD_W*NUM_WORDS-1:0]   RESET_VAL = 128'h5468697349734E6F74576F726B696E67
) (
  input  logic                clk_i,
  input  logic                rst_i,
  puf_resp_collector_if.slave bus
);

  localparam int RESP_W = WORD_W * NUM_WORDS;
  localparam int CNT_W  = $clog2(VOTES + 1);
  localparam int WIDX_W = $clog2(NUM_WORDS + 1);
  localparam int SET_W  = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    Idle    = 3'd0,
    Load    = 3'd1,
    Eval    = 3'd2,
    Capture = 3'd3,
    Done    = 3'd4
  } state_e;

  state_e                         state_q, state_d;
  logic [WORD_W-1:0]              lfsr_q, lfsr_d;
  logic [SET_W-1:0]               settleCnt_q, settleCnt_d;
  logic [CNT_W-1:0]               voteIdx_q, voteIdx_d;
  logic [WIDX_W-1:0]              wordIdx_q, wordIdx_d;
  logic [WORD_W-1:0][CNT_W-1:0]   voteCnt_q, voteCnt_d;
  logic [RESP_W-1:0]              staging_q, staging_d;
  logic [RESP_W-1:0]              respOut_q, respOut_d;
  logic                           respValid_q, respValid_d;

  logic [WORD_W-1:0][CNT_W-1:0]   sumCnt;
  logic [WORD_W-1:0]              majWord;
  logic [CNT_W-1:0]               voteIdxInc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= Idle;
      lfsr_q      <= '0;
      settleCnt_q <= '0;
      voteIdx_q   <= '0;
      wordIdx_q   <= '0;
      voteCnt_q   <= '0;
      staging_q   <= '0;
      respOut_q   <= RESET_VAL;
      respValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      settleCnt_q <= settleCnt_d;
      voteIdx_q   <= voteIdx_d;
      wordIdx_q   <= wordIdx_d;
      voteCnt_q   <= voteCnt_d;
      staging_q   <= staging_d;
      respOut_q   <= respOut_d;
      respValid_q <= respValid_d;
    end
  end

  // Running vote totals including the sample currently on puf_response.
  always_comb begin
    sumCnt  = '0;
    majWord = '0;
    for (int i = 0; i < WORD_W; i++) begin
      sumCnt[i]  = voteCnt_q[i] + CNT_W'(bus.puf_response[i]);
      majWord[i] = (sumCnt[i] > CNT_W'(VOTES / 2));
    end
    voteIdxInc = voteIdx_q + CNT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    settleCnt_d = settleCnt_q;
    voteIdx_d   = voteIdx_q;
    wordIdx_d   = wordIdx_q;
    voteCnt_d   = voteCnt_q;
    staging_d   = staging_q;
    respOut_d   = respOut_q;
    respValid_d = respValid_q;

    case (state_q)
      Idle: begin
        if (bus.start && !bus.abort) begin
          state_d     = Load;
          respValid_d = 1'b0;
        end
      end
      Load: begin
        lfsr_d      = (bus.seed == '0) ? WORD_W'(1) : bus.seed;
        settleCnt_d = '0;
        voteIdx_d   = '0;
        wordIdx_d   = '0;
        voteCnt_d   = '0;
        state_d     = Eval;
      end
      Eval: begin
        if (settleCnt_q == SET_W'(SETTLE - 1)) begin
          settleCnt_d = '0;
          state_d     = Capture;
        end else begin
          settleCnt_d = settleCnt_q + SET_W'(1);
        end
      end
      Capture: begin
        if (voteIdxInc < CNT_W'(VOTES)) begin
          voteIdx_d = voteIdxInc;
          voteCnt_d = sumCnt;
          state_d   = Eval;
        end else begin
          // Shifting in from the LSB end leaves word 0 in the MSBs after a full run.
          staging_d = (staging_q << WORD_W) | RESP_W'(majWord);
          voteIdx_d = '0;
          voteCnt_d = '0;
          lfsr_d    = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
          wordIdx_d = wordIdx_q + WIDX_W'(1);
          state_d   = (wordIdx_q == WIDX_W'(NUM_WORDS - 1)) ? Done : Eval;
        end
      end
      Done: begin
        respOut_d   = staging_q;
        respValid_d = 1'b1;
        state_d     = Idle;
      end
      default: state_d = Idle;
    endcase

    // Abort overrides every transition, including the final commit.
    if (bus.abort && state_q != Idle) begin
      state_d     = Idle;
      respOut_d   = respOut_q;
      respValid_d = respValid_q;
    end
  end

  assign bus.puf_challenge = lfsr_q;
  assign bus.puf_eval      = (state_q == Eval);
  assign bus.resp_out      = respOut_q;
  assign bus.resp_valid    = respValid_q;
  assign bus.busy          = (state_q != Idle);
  assign bus.done          = (state_q == Done) && !bus.abort;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_puf_resp_collector.sv
// Directed, table-driven bench for puf_resp_collector: one single-vote instance
// and one three-vote instance fed by behavioural PUF models.
module tb_puf_resp_collector;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int RW = W * N;
  localparam logic [RW-1:0] RESET_VAL = 128'h5468697349734E6F74576F726B696E67;
  localparam logic [RW-1:0] RES_S1    = 128'hFFFE4BFFA5FFD2FFE97FF4BFFA5FFD2F;
  localparam logic [RW-1:0] RES_S3    = 128'hFFFC4BFE11FF88FFC47FE23FF11FF88F;
  localparam logic [RW-1:0] RES_S8000 = 128'h7FFFBFFFDFFFEFFFF7FFFBFFFDFFFEFF;

  typedef struct {
    logic          votes3;
    logic [W-1:0]  seed;
    logic [W-1:0]  expFirst;
    logic [RW-1:0] expResp;
    int            expLat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  puf_resp_collector_if #(.WORD_W(W), .NUM_WORDS(N)) bus1 ();
  puf_resp_collector_if #(.WORD_W(W), .NUM_WORDS(N)) bus3 ();

  puf_resp_collector dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
  puf_resp_collector #(.VOTES(3)) dut3 (.clk_i(clk), .rst_i(rst), .bus(bus3));

  // Ideal PUF for the single-vote instance: response is the inverted challenge.
  always_comb bus1.puf_response = ~bus1.puf_challenge;

  // Noisy PUF for the voting instance: bit0 wrong on sample 1, bit5 wrong on sample 2.
  int capCnt3 = 0;
  logic [W-1:0] flip3;
  always @(posedge clk) begin
    if (bus3.state == 3'd1) capCnt3 <= 0;
    else if (bus3.state == 3'd3) capCnt3 <= capCnt3 + 1;
  end
  always_comb begin
    flip3 = '0;
    if (capCnt3 % 3 == 1) flip3[0] = 1'b1;
    if (capCnt3 % 3 == 2) flip3[5] = 1'b1;
    bus3.puf_response = ~bus3.puf_challenge ^ flip3;
  end

  logic          sel3 = 1'b0;
  logic          doneS, evalS, validS, busyS;
  logic [2:0]    stateS;
  logic [W-1:0]  challS;
  logic [RW-1:0] respS;
  always_comb begin
    if (sel3) begin
      doneS = bus3.done; evalS = bus3.puf_eval; validS = bus3.resp_valid;
      busyS = bus3.busy; stateS = bus3.state; challS = bus3.puf_challenge;
      respS = bus3.resp_out;
    end else begin
      doneS = bus1.done; evalS = bus1.puf_eval; validS = bus1.resp_valid;
      busyS = bus1.busy; stateS = bus1.state; challS = bus1.puf_challenge;
      respS = bus1.resp_out;
    end
  end

  int nVec  = 0;
  int nMiss = 0;

  task automatic checkOutput(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic setStart(input logic val);
    if (sel3) bus3.start = val;
    else      bus1.start = val;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Starts a run in the current cycle and checks first challenge, latency and result.
  task automatic applyStimulus(input vec_t v, input logic [RW-1:0] oldResp);
    int doneAt;
    sel3      = v.votes3;
    bus1.seed = v.seed;
    bus3.seed = v.seed;
    setStart(1'b1);
    nextCycle();
    setStart(1'b0);
    doneAt = -1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (cyc == 2) begin
        checkOutput("first challenge", RW'(challS), RW'(v.expFirst));
        checkOutput("puf_eval in EVAL", RW'(evalS), RW'(1'b1));
      end
      if (cyc == 8) setStart(1'b1);
      if (cyc == 9) setStart(1'b0);
      if (doneS) begin
        doneAt = cyc;
        checkOutput("resp held at done", respS, oldResp);
        break;
      end
      nextCycle();
    end
    checkOutput("done latency", RW'(doneAt), RW'(v.expLat));
    nextCycle();
    checkOutput("resp_out", respS, v.expResp);
    checkOutput("resp_valid after run", RW'(validS), RW'(1'b1));
    checkOutput("state after run", RW'(stateS), RW'(3'd0));
  endtask

  vec_t vecs[5];
  logic [RW-1:0] lastResp1;
  bit doneSeen;

  initial begin
    vecs[0] = '{votes3: 1'b0, seed: 16'h0001, expFirst: 16'h0001, expResp: RES_S1,    expLat: 26};
    vecs[1] = '{votes3: 1'b0, seed: 16'h0000, expFirst: 16'h0001, expResp: RES_S1,    expLat: 26};
    vecs[2] = '{votes3: 1'b0, seed: 16'h0003, expFirst: 16'h0003, expResp: RES_S3,    expLat: 26};
    vecs[3] = '{votes3: 1'b0, seed: 16'h8000, expFirst: 16'h8000, expResp: RES_S8000, expLat: 26};
    vecs[4] = '{votes3: 1'b1, seed: 16'h0001, expFirst: 16'h0001, expResp: RES_S1,    expLat: 74};

    rst = 1'b1;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.seed = '0;
    bus3.start = 1'b0; bus3.abort = 1'b0; bus3.seed = '0;
    nextCycle();
    nextCycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) nextCycle();
    checkOutput("reset resp_out", bus1.resp_out, RESET_VAL);
    checkOutput("reset resp_valid", RW'(bus1.resp_valid), RW'(1'b0));
    checkOutput("reset busy", RW'(bus1.busy), RW'(1'b0));
    checkOutput("reset state", RW'(bus1.state), RW'(3'd0));
    checkOutput("reset puf_eval", RW'(bus1.puf_eval), RW'(1'b0));
    checkOutput("reset resp_out votes3", bus3.resp_out, RESET_VAL);

    // Back-to-back runs: each vector starts in the cycle right after the previous done.
    lastResp1 = RESET_VAL;
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].votes3) begin
        applyStimulus(vecs[i], RESET_VAL);
      end else begin
        applyStimulus(vecs[i], lastResp1);
        lastResp1 = vecs[i].expResp;
      end
    end

    // Abort in cycle 10 of a run.
    sel3 = 1'b0;
    nextCycle();
    bus1.seed  = 16'h0001;
    bus1.start = 1'b1;
    nextCycle();
    bus1.start = 1'b0;
    checkOutput("resp_valid cleared on start", RW'(bus1.resp_valid), RW'(1'b0));
    doneSeen = 1'b0;
    for (int cyc = 1; cyc < 10; cyc++) begin
      if (bus1.done) doneSeen = 1'b1;
      nextCycle();
    end
    bus1.abort = 1'b1;
    nextCycle();
    bus1.abort = 1'b0;
    checkOutput("abort state", RW'(bus1.state), RW'(3'd0));
    checkOutput("abort puf_eval", RW'(bus1.puf_eval), RW'(1'b0));
    checkOutput("abort resp_out kept", bus1.resp_out, lastResp1);
    checkOutput("abort resp_valid", RW'(bus1.resp_valid), RW'(1'b0));
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (bus1.done) doneSeen = 1'b1;
      nextCycle();
    end
    checkOutput("no done after abort", RW'(doneSeen), RW'(1'b0));

    // start and abort together in IDLE: nothing starts.
    bus1.start = 1'b1;
    bus1.abort = 1'b1;
    nextCycle();
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    checkOutput("start+abort idle state", RW'(bus1.state), RW'(3'd0));
    checkOutput("start+abort idle busy", RW'(bus1.busy), RW'(1'b0));

    // Reset in the middle of a run, then a clean run.
    bus1.seed  = 16'h0001;
    bus1.start = 1'b1;
    nextCycle();
    bus1.start = 1'b0;
    for (int cyc = 1; cyc < 12; cyc++) nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    checkOutput("mid-run reset state", RW'(bus1.state), RW'(3'd0));
    checkOutput("mid-run reset resp_out", bus1.resp_out, RESET_VAL);
    checkOutput("mid-run reset busy", RW'(bus1.busy), RW'(1'b0));
    nextCycle();
    applyStimulus(vecs[0], RESET_VAL);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
